// File: rtl/pipe_perf_pkg.sv
// pipe_perf_pkg
// Shared types and constants for the pipeline performance-monitor unit.
//   perf_state_e : monitor FSM states (IDLE, RUN, HALT)
//   SEL_*        : read-select codes, also the index of each counter
//   stall_event  : classifies a cycle as a load-use stall (a flush wins)
package pipe_perf_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } perf_state_e;

   localparam logic [1:0] SEL_CYC   = 2'd0;
   localparam logic [1:0] SEL_RET   = 2'd1;
   localparam logic [1:0] SEL_STALL = 2'd2;
   localparam logic [1:0] SEL_FLUSH = 2'd3;

   localparam int NUM_CNT = 4;

   // A cycle that is both stalled and flushed is reported only as a flush.
   function automatic logic stall_event(input logic stall, input logic flush);
      return stall & ~flush;
   endfunction

endpackage

// File: rtl/perf_sat_counter.sv
// perf_sat_counter
// Saturating event counter used for each performance statistic.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   clear    : synchronous clear, wins over counting
//   inc      : event strobe for this cycle
//   en       : counting window (monitor in RUN)
//   count    : current count, never wraps past all-ones
//   sat_hit  : one-cycle pulse when an increment is attempted at the maximum
module perf_sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             inc,
   input  logic             en,
   output logic [CNT_W-1:0] count,
   output logic             sat_hit
);

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] count_r;
   logic             bump_s;
   logic             sat_s;

   // Decide whether this edge increments or only records a saturation hit.
   always_comb begin
      bump_s = 1'b0;
      sat_s  = 1'b0;
      if (en && inc && !clear) begin
         if (count_r == CNT_MAX) begin
            sat_s = 1'b1;
         end else begin
            bump_s = 1'b1;
         end
      end else begin
         bump_s = 1'b0;
         sat_s  = 1'b0;
      end
   end

   // Count register with clear priority over increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= CNT_ZERO;
      end else if (clear) begin
         count_r <= CNT_ZERO;
      end else if (bump_s) begin
         count_r <= count_r + CNT_ONE;
      end else begin
         count_r <= count_r;
      end
   end

   assign count   = count_r;
   // Combinational so the owner can make its sticky flag rise on the same edge.
   assign sat_hit = sat_s;

endmodule

// File: rtl/pipe_perf_counter.sv
// pipe_perf_counter
// Performance monitor beside the hazard unit: counts run cycles, retired
// instructions, load-use stall cycles and flush cycles while running, keeps a
// shadow copy taken on snap_i and returns one shadow value through a
// registered read port.
// Ports:
//   clk_i     : clock, rising edge
//   rst_i     : asynchronous active-low reset
//   start_i   : CPU start, counting window while high
//   stall_i   : load-use bubble inserted this cycle
//   flush_i   : IF/ID flushed this cycle
//   retire_i  : valid instruction in MEM/WB this cycle
//   clear_i   : synchronous clear of counters, shadows, flag and FSM
//   snap_i    : copy live counters into shadows
//   sel_i     : read select (cycles, retired, stalls, flushes)
//   rd_data_o : selected shadow value, one cycle after sel_i
//   ovf_o     : sticky, some counter saturated
//   halted_o  : monitor stopped at CYCLE_LIMIT
module pipe_perf_counter
   import pipe_perf_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int CYCLE_LIMIT = 0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             stall_i,
   input  logic             flush_i,
   input  logic             retire_i,
   input  logic             clear_i,
   input  logic             snap_i,
   input  logic [1:0]       sel_i,
   output logic [CNT_W-1:0] rd_data_o,
   output logic             ovf_o,
   output logic             halted_o
);

   localparam bit               LIMIT_ON  = (CYCLE_LIMIT != 32'sd0);
   // One extra bit so a saturated cycle counter can never alias the limit.
   localparam logic [CNT_W:0]   LIMIT_EXT = (CNT_W+1)'(CYCLE_LIMIT);
   localparam logic [CNT_W:0]   EXT_ONE   = {{CNT_W{1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] ZERO_W    = {CNT_W{1'b0}};

   perf_state_e                     state_r;
   perf_state_e                     next_state_s;
   logic                            run_s;
   logic                            limit_hit_s;
   logic [CNT_W:0]                  cyc_next_s;
   logic [NUM_CNT-1:0]              inc_s;
   logic [NUM_CNT-1:0]              sat_hit_s;
   logic [NUM_CNT-1:0][CNT_W-1:0]   live_s;
   logic [NUM_CNT-1:0][CNT_W-1:0]   shadow_r;
   logic [CNT_W-1:0]                rd_data_r;
   logic                            ovf_r;
   logic                            halted_r;

   // Counting window and the edge on which the cycle count reaches the limit.
   always_comb begin
      run_s       = (state_r == RUN) && !clear_i;
      cyc_next_s  = {1'b0, live_s[SEL_CYC]} + EXT_ONE;
      limit_hit_s = LIMIT_ON && run_s && (cyc_next_s == LIMIT_EXT);
   end

   // Per-counter event strobes, indexed by read-select code.
   always_comb begin
      inc_s            = 4'b0000;
      inc_s[SEL_CYC]   = 1'b1;
      inc_s[SEL_RET]   = retire_i;
      inc_s[SEL_STALL] = stall_event(stall_i, flush_i);
      inc_s[SEL_FLUSH] = flush_i;
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
         perf_sat_counter #(
            .CNT_W (CNT_W)
         ) u_cnt (
            .clk     (clk_i),
            .rst_n   (rst_i),
            .clear   (clear_i),
            .inc     (inc_s[gi]),
            .en      (run_s),
            .count   (live_s[gi]),
            .sat_hit (sat_hit_s[gi])
         );
      end
   endgenerate

   // Next-state logic; clear overrides everything and HALT ignores start_i.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start_i) begin
               next_state_s = RUN;
            end else begin
               next_state_s = IDLE;
            end
         end
         RUN: begin
            if (limit_hit_s) begin
               next_state_s = HALT;
            end else if (!start_i) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = RUN;
            end
         end
         HALT: begin
            next_state_s = HALT;
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
      if (clear_i) begin
         next_state_s = IDLE;
      end else begin
         next_state_s = next_state_s;
      end
   end

   // FSM state register and halted flag decoded from the incoming state.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_r  <= IDLE;
         halted_r <= 1'b0;
      end else begin
         state_r  <= next_state_s;
         halted_r <= (next_state_s == HALT);
      end
   end

   // Shadow capture and sticky overflow; shadows see pre-edge live values.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         shadow_r <= {(NUM_CNT*CNT_W){1'b0}};
         ovf_r    <= 1'b0;
      end else if (clear_i) begin
         shadow_r <= {(NUM_CNT*CNT_W){1'b0}};
         ovf_r    <= 1'b0;
      end else begin
         if (snap_i) begin
            shadow_r <= live_s;
         end else begin
            shadow_r <= shadow_r;
         end
         ovf_r <= ovf_r | (|sat_hit_s);
      end
   end

   // Registered read port, always showing the shadow selected last cycle.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rd_data_r <= ZERO_W;
      end else begin
         rd_data_r <= shadow_r[sel_i];
      end
   end

   assign rd_data_o = rd_data_r;
   assign ovf_o     = ovf_r;
   assign halted_o  = halted_r;

endmodule

// File: tb/tb_pipe_perf_counter.sv
// tb_pipe_perf_counter
// Drives three monitor instances (32-bit free running, 32-bit with a limit of
// 30, 4-bit free running) from one set of directed strobes, compares every
// cycle against a per-instance event model and pins key values by hand.
module tb_pipe_perf_counter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, stall, flush, retire, clear, snap;
   logic [1:0]  sel;
   logic [31:0] rd_a, rd_b;
   logic [3:0]  rd_c;
   logic        ovf_a, ovf_b, ovf_c;
   logic        halt_a, halt_b, halt_c;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // model: per instance live counts, shadows, read value, flag, mode
   // mode 0 = stopped, 1 = counting, 2 = stopped at limit
   longint unsigned m_cnt [3][4];
   longint unsigned m_shd [3][4];
   longint unsigned m_rd  [3];
   longint unsigned m_max [3];
   bit              m_ovf [3];
   bit              m_halt[3];
   int              m_mode[3];
   int              m_lim [3];

   always #5 clk = ~clk;

   pipe_perf_counter #(.CNT_W(32), .CYCLE_LIMIT(0)) dut_a (
      .clk_i(clk), .rst_i(rst_n), .start_i(start), .stall_i(stall),
      .flush_i(flush), .retire_i(retire), .clear_i(clear), .snap_i(snap),
      .sel_i(sel), .rd_data_o(rd_a), .ovf_o(ovf_a), .halted_o(halt_a));

   pipe_perf_counter #(.CNT_W(32), .CYCLE_LIMIT(30)) dut_b (
      .clk_i(clk), .rst_i(rst_n), .start_i(start), .stall_i(stall),
      .flush_i(flush), .retire_i(retire), .clear_i(clear), .snap_i(snap),
      .sel_i(sel), .rd_data_o(rd_b), .ovf_o(ovf_b), .halted_o(halt_b));

   pipe_perf_counter #(.CNT_W(4), .CYCLE_LIMIT(0)) dut_c (
      .clk_i(clk), .rst_i(rst_n), .start_i(start), .stall_i(stall),
      .flush_i(flush), .retire_i(retire), .clear_i(clear), .snap_i(snap),
      .sel_i(sel), .rd_data_o(rd_c), .ovf_o(ovf_c), .halted_o(halt_c));

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         for (int k = 0; k < 4; k++) begin
            m_cnt[i][k] = 64'd0;
            m_shd[i][k] = 64'd0;
         end
         m_rd[i]   = 64'd0;
         m_ovf[i]  = 1'b0;
         m_halt[i] = 1'b0;
         m_mode[i] = 0;
      end
   endtask

   // One clock edge of every instance, from the strobes as sampled on it.
   task automatic model_step();
      bit              ev[4];
      longint unsigned cyc_before;
      ev[0] = 1'b1;
      ev[1] = retire;
      ev[2] = stall && !flush;
      ev[3] = flush;
      for (int i = 0; i < 3; i++) begin
         m_rd[i] = m_shd[i][sel];
         if (clear) begin
            for (int k = 0; k < 4; k++) begin
               m_cnt[i][k] = 64'd0;
               m_shd[i][k] = 64'd0;
            end
            m_ovf[i]  = 1'b0;
            m_mode[i] = 0;
         end else begin
            if (snap) begin
               for (int k = 0; k < 4; k++) m_shd[i][k] = m_cnt[i][k];
            end
            if (m_mode[i] == 1) begin
               cyc_before = m_cnt[i][0];
               for (int k = 0; k < 4; k++) begin
                  if (ev[k]) begin
                     if (m_cnt[i][k] == m_max[i]) m_ovf[i] = 1'b1;
                     else m_cnt[i][k] = m_cnt[i][k] + 64'd1;
                  end
               end
               if (m_lim[i] != 0 && m_cnt[i][0] != cyc_before &&
                   m_cnt[i][0] == longint'(m_lim[i]))
                  m_mode[i] = 2;
               else if (!start)
                  m_mode[i] = 0;
            end else if (m_mode[i] == 0 && start) begin
               m_mode[i] = 1;
            end
         end
         m_halt[i] = (m_mode[i] == 2);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         model_step();
         @(negedge clk);
      end
   endtask

   function automatic logic [63:0] dut_rd(input int i);
      case (i)
         0:       return {32'd0, rd_a};
         1:       return {32'd0, rd_b};
         default: return {60'd0, rd_c};
      endcase
   endfunction

   function automatic logic dut_ovf(input int i);
      case (i)
         0:       return ovf_a;
         1:       return ovf_b;
         default: return ovf_c;
      endcase
   endfunction

   function automatic logic dut_halt(input int i);
      case (i)
         0:       return halt_a;
         1:       return halt_b;
         default: return halt_c;
      endcase
   endfunction

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         for (int i = 0; i < 3; i++) begin
            check($sformatf("model_rd%0d", i), dut_rd(i), m_rd[i]);
            check($sformatf("model_ovf%0d", i), {63'd0, dut_ovf(i)}, {63'd0, m_ovf[i]});
            check($sformatf("model_halt%0d", i), {63'd0, dut_halt(i)}, {63'd0, m_halt[i]});
         end
      end
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; stall = 1'b0; flush = 1'b0;
      retire = 1'b0; clear = 1'b0; snap = 1'b0; sel = 2'd0;
      m_max[0] = 64'hFFFF_FFFF; m_max[1] = 64'hFFFF_FFFF; m_max[2] = 64'd15;
      m_lim[0] = 0; m_lim[1] = 30; m_lim[2] = 0;
      model_reset();
      repeat (2) @(negedge clk);
      check("reset_rd", rd_a, 0);
      check("reset_ovf", ovf_a, 0);
      check("reset_halt", halt_b, 0);
      rst_n  = 1'b1;
      chk_en = 1'b1;

      // 1: ten running cycles, all retiring, then snapshot and read back
      start = 1'b1; retire = 1'b1;
      tick(11);
      snap = 1'b1; retire = 1'b0; start = 1'b0;
      tick(1);
      snap = 1'b0; sel = 2'd0; tick(1); check("t1_cycles", rd_a, 10);
      sel = 2'd1; tick(1); check("t1_retired", rd_a, 10);
      sel = 2'd2; tick(1); check("t1_stalls", rd_a, 0);
      sel = 2'd3; tick(1); check("t1_flushes", rd_a, 0);

      // 2: stall/flush classification, snap and sel changing together
      clear = 1'b1; tick(1); clear = 1'b0;
      start = 1'b1; tick(1);
      stall = 1'b1; tick(3);
      stall = 1'b0; flush = 1'b1; tick(2);
      stall = 1'b1; tick(1);
      stall = 1'b0; flush = 1'b0; snap = 1'b1; sel = 2'd2;
      tick(1); check("t2_sel_first_edge", rd_a, 0);
      snap = 1'b0; tick(1); check("t2_stalls", rd_a, 3);
      sel = 2'd3; tick(1); check("t2_flushes", rd_a, 3);
      sel = 2'd0; tick(1); check("t2_cycles", rd_a, 6);

      // 5: start dropped with stall held; only the leaving edge counts
      stall = 1'b1; start = 1'b0; sel = 2'd2;
      tick(4);
      snap = 1'b1; tick(1); snap = 1'b0; tick(1);
      check("t5_idle_stalls", rd_a, 4);
      start = 1'b1; tick(3);
      stall = 1'b0; snap = 1'b1; tick(1); snap = 1'b0; tick(1);
      check("t5_resumed_stalls", rd_a, 6);

      // 3: cycle limit of 30 on dut_b
      start = 1'b0; clear = 1'b1; sel = 2'd0; tick(1); clear = 1'b0;
      start = 1'b1; tick(1);
      tick(29); check("t3_halt_before", halt_b, 0);
      tick(1);  check("t3_halt_edge30", halt_b, 1);
      snap = 1'b1; tick(1); snap = 1'b0; tick(1);
      check("t3_cycles_at_halt", rd_b, 30);
      start = 1'b0; tick(2); start = 1'b1; tick(3);
      check("t3_halt_ignores_start", halt_b, 1);
      snap = 1'b1; tick(1); snap = 1'b0; tick(1);
      check("t3_cycles_frozen", rd_b, 30);
      start = 1'b0; clear = 1'b1; tick(1); clear = 1'b0;
      check("t3_halt_cleared", halt_b, 0);
      for (int s = 0; s < 4; s++) begin
         tick(1);
         check($sformatf("t3_read_zero_sel%0d", sel), rd_b, 0);
         sel = sel + 2'd1;
      end

      // 4: 4-bit flush counter saturation on dut_c
      sel = 2'd3; clear = 1'b1; tick(1); clear = 1'b0;
      start = 1'b1; tick(1);
      flush = 1'b1; tick(15); check("t4_ovf_before", ovf_c, 0);
      tick(1); check("t4_ovf_16th", ovf_c, 1);
      tick(4);
      flush = 1'b0; snap = 1'b1; tick(1); snap = 1'b0; tick(1);
      check("t4_flush_sat", rd_c, 15);
      check("t4_ovf_sticky", ovf_c, 1);
      check("t4_flush_wide", rd_a, 20);

      // 6: asynchronous reset between edges while running
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check("t6_rd_async", rd_a, 0);
      check("t6_rdc_async", rd_c, 0);
      check("t6_ovf_async", ovf_c, 0);
      check("t6_halt_async", halt_b, 0);
      @(negedge clk);
      rst_n = 1'b1;
      retire = 1'b1;
      tick(4);
      retire = 1'b0; sel = 2'd0; snap = 1'b1; tick(1); snap = 1'b0; tick(1);
      check("t6_restart_cycles", rd_a, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
